// File: rtl/ex_issue_buffer_if.sv
// ---------------------------------------------------------------------------
// ex_issue_buffer_if
// Bundles the ID-side issue handshake, the EX-side head outputs and the two
// bypass (forwarding) buses of the EX issue buffer.
//   slave  : view used by ex_issue_buffer (consumes id_*/ex_ready/fwd_*,
//            produces id_ready/alu_enable/ex_*)
//   master : view used by the environment driving the buffer
// Parameters: OP_W (ALU op width), REG_AW (register address width).
// ---------------------------------------------------------------------------
interface ex_issue_buffer_if #(
   parameter int OP_W   = 8,
   parameter int REG_AW = 5
);
   // ID -> buffer
   logic              id_valid;
   logic              id_ready;
   logic [OP_W-1:0]   id_op;
   logic [31:0]       id_srcl;
   logic [31:0]       id_srcr;
   logic [REG_AW-1:0] id_rs_addr;
   logic [REG_AW-1:0] id_rt_addr;
   logic              id_rs_use;
   logic              id_rt_use;
   logic [REG_AW-1:0] id_dest;
   logic              id_dest_we;
   // buffer -> EX
   logic              ex_ready;
   logic              alu_enable;
   logic [OP_W-1:0]   ex_op;
   logic [31:0]       ex_srcl;
   logic [31:0]       ex_srcr;
   logic [REG_AW-1:0] ex_dest;
   logic              ex_dest_we;
   // bypass sources
   logic              fwd_ex_we;
   logic [REG_AW-1:0] fwd_ex_addr;
   logic [31:0]       fwd_ex_data;
   logic              fwd_mem_we;
   logic [REG_AW-1:0] fwd_mem_addr;
   logic [31:0]       fwd_mem_data;

   modport slave (
      input  id_valid, id_op, id_srcl, id_srcr, id_rs_addr, id_rt_addr,
             id_rs_use, id_rt_use, id_dest, id_dest_we, ex_ready,
             fwd_ex_we, fwd_ex_addr, fwd_ex_data,
             fwd_mem_we, fwd_mem_addr, fwd_mem_data,
      output id_ready, alu_enable, ex_op, ex_srcl, ex_srcr, ex_dest, ex_dest_we
   );

   modport master (
      output id_valid, id_op, id_srcl, id_srcr, id_rs_addr, id_rt_addr,
             id_rs_use, id_rt_use, id_dest, id_dest_we, ex_ready,
             fwd_ex_we, fwd_ex_addr, fwd_ex_data,
             fwd_mem_we, fwd_mem_addr, fwd_mem_data,
      input  id_ready, alu_enable, ex_op, ex_srcl, ex_srcr, ex_dest, ex_dest_we
   );
endinterface

// File: rtl/ex_issue_buffer.sv
// ---------------------------------------------------------------------------
// ex_issue_buffer
// ID->EX issue stage: a two-entry skid buffer (HEAD drives the ALU, SKID
// absorbs one instruction while EX stalls) with operand bypass from the EX
// and MEM stages and a synchronous flush.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   flush - drop every buffered instruction (and any offered this cycle)
//   bus   - ex_issue_buffer_if.slave: id_* handshake in, ex_* head out,
//           fwd_ex_* / fwd_mem_* bypass inputs
// Build option: define EX_ISSUE_FORWARD_EN to build the bypass muxes; when
// undefined, operands pass through from ID untouched and fwd_* is ignored.
// ---------------------------------------------------------------------------
module ex_issue_buffer #(
   parameter int OP_W   = 8,
   parameter int REG_AW = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   ex_issue_buffer_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   // rs/rt and their use bits travel with each entry so held entries can
   // keep picking up bypass results while EX stalls.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [31:0]       srcl;
      logic [31:0]       srcr;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              rs_use;
      logic              rt_use;
      logic [REG_AW-1:0] dest;
      logic              dest_we;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   logic   alu_enable_q, alu_enable_d;
   logic   id_ready_q, id_ready_d;

   entry_t in_s;
   entry_t head_fw_s;
   entry_t skid_fw_s;
   logic   accept_s;
   logic   pop_s;

`ifdef EX_ISSUE_FORWARD_EN
   // EX result wins over MEM; register 0 and immediates are never replaced.
   function automatic logic [31:0] fwd_operand(
      input logic [31:0]       val,
      input logic [REG_AW-1:0] addr,
      input logic              use_reg,
      input logic              ex_we,
      input logic [REG_AW-1:0] ex_addr,
      input logic [31:0]       ex_data,
      input logic              mem_we,
      input logic [REG_AW-1:0] mem_addr,
      input logic [31:0]       mem_data
   );
      logic [31:0] res;
      res = val;
      if (use_reg && (addr != '0)) begin
         if (ex_we && (ex_addr == addr)) begin
            res = ex_data;
         end else if (mem_we && (mem_addr == addr)) begin
            res = mem_data;
         end else begin
            res = val;
         end
      end else begin
         res = val;
      end
      return res;
   endfunction
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                           bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data};
`endif

   assign accept_s = bus.id_valid & id_ready_q;
   assign pop_s    = alu_enable_q & bus.ex_ready;

   // Incoming instruction and bypass-refreshed copies of the held entries.
   always_comb begin
      in_s.op      = bus.id_op;
      in_s.srcl    = bus.id_srcl;
      in_s.srcr    = bus.id_srcr;
      in_s.rs      = bus.id_rs_addr;
      in_s.rt      = bus.id_rt_addr;
      in_s.rs_use  = bus.id_rs_use;
      in_s.rt_use  = bus.id_rt_use;
      in_s.dest    = bus.id_dest;
      in_s.dest_we = bus.id_dest_we;
      head_fw_s    = head_q;
      skid_fw_s    = skid_q;
`ifdef EX_ISSUE_FORWARD_EN
      in_s.srcl = fwd_operand(in_s.srcl, in_s.rs, in_s.rs_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
      in_s.srcr = fwd_operand(in_s.srcr, in_s.rt, in_s.rt_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
      head_fw_s.srcl = fwd_operand(head_q.srcl, head_q.rs, head_q.rs_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
      head_fw_s.srcr = fwd_operand(head_q.srcr, head_q.rt, head_q.rt_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
      skid_fw_s.srcl = fwd_operand(skid_q.srcl, skid_q.rs, skid_q.rs_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
      skid_fw_s.srcr = fwd_operand(skid_q.srcr, skid_q.rt, skid_q.rt_use,
                              bus.fwd_ex_we, bus.fwd_ex_addr, bus.fwd_ex_data,
                              bus.fwd_mem_we, bus.fwd_mem_addr, bus.fwd_mem_data);
`endif
   end

   // Next-state, entry movement and registered-output precompute.
   always_comb begin
      state_d = state_q;
      head_d  = head_fw_s;
      skid_d  = skid_fw_s;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_s) begin
                  head_d  = in_s;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && pop_s) begin
                  head_d  = in_s;
                  state_d = ST_ONE;
               end else if (accept_s) begin
                  skid_d  = in_s;
                  state_d = ST_TWO;
               end else if (pop_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_TWO: begin
               if (pop_s) begin
                  head_d  = skid_fw_s;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_TWO;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      // An empty buffer must never present a register write to EX.
      head_d.dest_we = head_d.dest_we & (state_d != ST_EMPTY);
      alu_enable_d   = (state_d != ST_EMPTY);
      id_ready_d     = (state_d != ST_TWO);
   end

   // State, entries and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         head_q       <= '0;
         skid_q       <= '0;
         alu_enable_q <= 1'b0;
         id_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         skid_q       <= skid_d;
         alu_enable_q <= alu_enable_d;
         id_ready_q   <= id_ready_d;
      end
   end

   assign bus.id_ready   = id_ready_q;
   assign bus.alu_enable = alu_enable_q;
   assign bus.ex_op      = head_q.op;
   assign bus.ex_srcl    = head_q.srcl;
   assign bus.ex_srcr    = head_q.srcr;
   assign bus.ex_dest    = head_q.dest;
   assign bus.ex_dest_we = head_q.dest_we;

endmodule

// File: tb/tb_ex_issue_buffer.sv
// ---------------------------------------------------------------------------
// tb_ex_issue_buffer
// Self-checking bench for ex_issue_buffer. A queue-based model (at most two
// in-flight instructions, oldest at the front) predicts the head outputs.
// Bypass expectations follow EX_ISSUE_FORWARD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ex_issue_buffer;

`ifdef EX_ISSUE_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   ex_issue_buffer_if #(.OP_W(8), .REG_AW(5)) bus ();

   ex_issue_buffer #(.OP_W(8), .REG_AW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] srcl;
      logic [31:0] srcr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        rs_use;
      logic        rt_use;
      logic [4:0]  dest;
      logic        dest_we;
   } ent_t;

   ent_t mq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic        s_ex_we, s_mem_we;
   logic [4:0]  s_ex_a, s_mem_a;
   logic [31:0] s_ex_d, s_mem_d;

   function automatic logic [31:0] fwd_val(logic [31:0] v, logic [4:0] a, logic u);
      if (FWD_ON && u && (a != 5'd0)) begin
         if (s_ex_we && (s_ex_a == a)) return s_ex_d;
         if (s_mem_we && (s_mem_a == a)) return s_mem_d;
      end
      return v;
   endfunction

   // One clock: snapshot inputs, let the DUT clock, update the model, settle.
   task automatic cycle();
      ent_t inc, t;
      bit acc, popv, fl;
      s_ex_we = bus.fwd_ex_we;   s_ex_a = bus.fwd_ex_addr;   s_ex_d = bus.fwd_ex_data;
      s_mem_we = bus.fwd_mem_we; s_mem_a = bus.fwd_mem_addr; s_mem_d = bus.fwd_mem_data;
      inc.op = bus.id_op; inc.srcl = bus.id_srcl; inc.srcr = bus.id_srcr;
      inc.rs = bus.id_rs_addr; inc.rt = bus.id_rt_addr;
      inc.rs_use = bus.id_rs_use; inc.rt_use = bus.id_rt_use;
      inc.dest = bus.id_dest; inc.dest_we = bus.id_dest_we;
      acc  = bus.id_valid && (mq.size() < 2);
      popv = bus.ex_ready && (mq.size() > 0);
      fl   = flush;
      @(posedge clk);
      for (int i = 0; i < mq.size(); i++) begin
         t = mq[i];
         t.srcl = fwd_val(t.srcl, t.rs, t.rs_use);
         t.srcr = fwd_val(t.srcr, t.rt, t.rt_use);
         mq[i] = t;
      end
      inc.srcl = fwd_val(inc.srcl, inc.rs, inc.rs_use);
      inc.srcr = fwd_val(inc.srcr, inc.rt, inc.rt_use);
      if (fl) begin
         mq.delete();
      end else begin
         if (popv) void'(mq.pop_front());
         if (acc) mq.push_back(inc);
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.id_valid = 1'b0; bus.id_op = 8'h00; bus.id_srcl = 32'h0; bus.id_srcr = 32'h0;
      bus.id_rs_addr = 5'd0; bus.id_rt_addr = 5'd0; bus.id_rs_use = 1'b0; bus.id_rt_use = 1'b0;
      bus.id_dest = 5'd0; bus.id_dest_we = 1'b0; bus.ex_ready = 1'b0;
      bus.fwd_ex_we = 1'b0; bus.fwd_ex_addr = 5'd0; bus.fwd_ex_data = 32'h0;
      bus.fwd_mem_we = 1'b0; bus.fwd_mem_addr = 5'd0; bus.fwd_mem_data = 32'h0;
      flush = 1'b0;
   endtask

   task automatic offer(logic [7:0] op, logic [31:0] l, logic [31:0] r,
                        logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                        logic [4:0] d, logic dwe);
      bus.id_valid = 1'b1; bus.id_op = op; bus.id_srcl = l; bus.id_srcr = r;
      bus.id_rs_addr = rs; bus.id_rs_use = rsu; bus.id_rt_addr = rt; bus.id_rt_use = rtu;
      bus.id_dest = d; bus.id_dest_we = dwe;
   endtask

   task automatic drain();
      bus.id_valid = 1'b0; bus.ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      bus.ex_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #12;
      n_checks++;
      if ({bus.alu_enable, bus.ex_op, bus.ex_srcl, bus.ex_srcr, bus.ex_dest, bus.ex_dest_we} !== 79'd0) begin
         n_fail++; $display("FAIL reset_outputs got en=%b op=%h l=%h r=%h d=%h we=%b, want all 0",
            bus.alu_enable, bus.ex_op, bus.ex_srcl, bus.ex_srcr, bus.ex_dest, bus.ex_dest_we);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete();
      cycle();
      n_checks++;
      if (bus.id_ready !== 1'b1 || bus.alu_enable !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got rdy=%b en=%b, want rdy=1 en=0", bus.id_ready, bus.alu_enable);
      end
   endtask

   task automatic test_single_issue();
      bus.ex_ready = 1'b1;
      offer(8'h05, 32'h0000FFFF, 32'h00FF00FF, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
      cycle();
      bus.id_valid = 1'b0;
      n_checks++;
      if (bus.alu_enable !== 1'b1 || bus.ex_op !== 8'h05 || bus.ex_srcl !== 32'h0000FFFF ||
          bus.ex_srcr !== 32'h00FF00FF || bus.ex_dest !== 5'd4 || bus.ex_dest_we !== 1'b1) begin
         n_fail++; $display("FAIL single_issue got en=%b op=%h l=%h r=%h d=%0d we=%b, want 1 05 0000ffff 00ff00ff 4 1",
            bus.alu_enable, bus.ex_op, bus.ex_srcl, bus.ex_srcr, bus.ex_dest, bus.ex_dest_we);
      end
      cycle();
      n_checks++;
      if (bus.alu_enable !== 1'b0 || bus.ex_dest_we !== 1'b0) begin
         n_fail++; $display("FAIL single_after got en=%b we=%b, want 0 0", bus.alu_enable, bus.ex_dest_we);
      end
   endtask

   task automatic test_back_pressure();
      bus.ex_ready = 1'b0;
      offer(8'h11, 32'hAAAA0001, 32'h1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
      cycle();
      offer(8'h22, 32'hBBBB0002, 32'h2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0);
      cycle();
      bus.id_valid = 1'b0;
      n_checks++;
      if (bus.id_ready !== 1'b0 || bus.alu_enable !== 1'b1 || bus.ex_srcl !== 32'hAAAA0001 || bus.ex_op !== 8'h11) begin
         n_fail++; $display("FAIL bp_full got rdy=%b en=%b l=%h op=%h, want 0 1 aaaa0001 11",
            bus.id_ready, bus.alu_enable, bus.ex_srcl, bus.ex_op);
      end
      cycle();
      n_checks++;
      if (bus.id_ready !== 1'b0 || bus.ex_srcl !== 32'hAAAA0001) begin
         n_fail++; $display("FAIL bp_hold got rdy=%b l=%h, want 0 aaaa0001", bus.id_ready, bus.ex_srcl);
      end
      bus.ex_ready = 1'b1;
      cycle();
      n_checks++;
      if (bus.id_ready !== 1'b1 || bus.alu_enable !== 1'b1 || bus.ex_srcl !== 32'hBBBB0002 ||
          bus.ex_op !== 8'h22 || bus.ex_dest_we !== 1'b0) begin
         n_fail++; $display("FAIL bp_release got rdy=%b en=%b l=%h op=%h we=%b, want 1 1 bbbb0002 22 0",
            bus.id_ready, bus.alu_enable, bus.ex_srcl, bus.ex_op, bus.ex_dest_we);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      bus.ex_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(8'h30, 32'(i), 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
         cycle();
         n_checks++;
         if (bus.alu_enable !== 1'b1 || bus.ex_srcl !== 32'(i) || bus.id_ready !== 1'b1) begin
            n_fail++; $display("FAIL throughput[%0d] got en=%b l=%h rdy=%b, want 1 %h 1",
               i, bus.alu_enable, bus.ex_srcl, bus.id_ready, 32'(i));
         end
      end
      drain();
   endtask

   task automatic test_forwarding();
      logic [31:0] exp;
      bus.ex_ready = 1'b1;
      offer(8'h40, 32'h11, 32'h22, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
      bus.fwd_ex_we = 1'b1; bus.fwd_ex_addr = 5'd3; bus.fwd_ex_data = 32'hAAAA;
      bus.fwd_mem_we = 1'b1; bus.fwd_mem_addr = 5'd3; bus.fwd_mem_data = 32'hBBBB;
      cycle();
      exp = FWD_ON ? 32'hAAAA : 32'h11;
      n_checks++;
      if (bus.ex_srcl !== exp || bus.alu_enable !== 1'b1) begin
         n_fail++; $display("FAIL fwd_ex_prio got l=%h en=%b, want %h 1", bus.ex_srcl, bus.alu_enable, exp);
      end
      offer(8'h41, 32'h11, 32'h22, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1);
      cycle();
      n_checks++;
      if (bus.ex_srcl !== 32'h11 || bus.ex_srcr !== 32'h22) begin
         n_fail++; $display("FAIL fwd_r0 got l=%h r=%h, want 00000011 00000022", bus.ex_srcl, bus.ex_srcr);
      end
      offer(8'h42, 32'h11, 32'h22, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
      bus.fwd_ex_we = 1'b0;
      cycle();
      exp = FWD_ON ? 32'hBBBB : 32'h11;
      n_checks++;
      if (bus.ex_srcl !== exp) begin
         n_fail++; $display("FAIL fwd_mem got l=%h, want %h", bus.ex_srcl, exp);
      end
      bus.fwd_mem_we = 1'b0;
      drain();
   endtask

   task automatic test_stall_refresh();
      logic [31:0] exp;
      bus.ex_ready = 1'b0;
      offer(8'h50, 32'h1, 32'h55, 5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b1);
      cycle();
      bus.id_valid = 1'b0;
      n_checks++;
      if (bus.ex_srcr !== 32'h55) begin
         n_fail++; $display("FAIL refresh_pre got r=%h, want 00000055", bus.ex_srcr);
      end
      bus.fwd_mem_we = 1'b1; bus.fwd_mem_addr = 5'd7; bus.fwd_mem_data = 32'h1234;
      cycle();
      bus.fwd_mem_we = 1'b0;
      exp = FWD_ON ? 32'h1234 : 32'h55;
      n_checks++;
      if (bus.ex_srcr !== exp || bus.alu_enable !== 1'b1) begin
         n_fail++; $display("FAIL refresh got r=%h en=%b, want %h 1", bus.ex_srcr, bus.alu_enable, exp);
      end
      drain();
   endtask

   task automatic test_flush();
      bus.ex_ready = 1'b0;
      offer(8'h60, 32'h6, 32'h6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      cycle();
      offer(8'h61, 32'h7, 32'h7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      cycle();
      offer(8'h62, 32'h8, 32'h8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
      bus.ex_ready = 1'b1;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      bus.id_valid = 1'b0;
      n_checks++;
      if (bus.alu_enable !== 1'b0 || bus.ex_dest_we !== 1'b0 || bus.id_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush got en=%b we=%b rdy=%b, want 0 0 1",
            bus.alu_enable, bus.ex_dest_we, bus.id_ready);
      end
      cycle();
      n_checks++;
      if (bus.alu_enable !== 1'b0) begin
         n_fail++; $display("FAIL flush_after got en=%b, want 0", bus.alu_enable);
      end
   endtask

   task automatic test_async_reset();
      bus.ex_ready = 1'b0;
      offer(8'h70, 32'h70, 32'h71, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      cycle();
      cycle();
      bus.id_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      mq.delete();
      n_checks++;
      if (bus.alu_enable !== 1'b0 || bus.id_ready !== 1'b1 || bus.ex_srcl !== 32'h0 ||
          bus.ex_op !== 8'h00 || bus.ex_dest_we !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got en=%b rdy=%b l=%h op=%h we=%b, want 0 1 0 0 0",
            bus.alu_enable, bus.id_ready, bus.ex_srcl, bus.ex_op, bus.ex_dest_we);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic exp_en, exp_rdy, exp_we;
      for (int c = 0; c < 600; c++) begin
         bus.id_valid = ($urandom_range(0, 9) < 7);
         bus.id_op = 8'($urandom); bus.id_srcl = $urandom; bus.id_srcr = $urandom;
         bus.id_rs_addr = 5'($urandom_range(0, 3)); bus.id_rt_addr = 5'($urandom_range(0, 3));
         bus.id_rs_use = 1'($urandom); bus.id_rt_use = 1'($urandom);
         bus.id_dest = 5'($urandom); bus.id_dest_we = 1'($urandom);
         bus.ex_ready = ($urandom_range(0, 2) != 0);
         bus.fwd_ex_we = 1'($urandom); bus.fwd_ex_addr = 5'($urandom_range(0, 3)); bus.fwd_ex_data = $urandom;
         bus.fwd_mem_we = 1'($urandom); bus.fwd_mem_addr = 5'($urandom_range(0, 3)); bus.fwd_mem_data = $urandom;
         flush = ($urandom_range(0, 15) == 0);
         cycle();
         exp_en  = (mq.size() > 0);
         exp_rdy = (mq.size() < 2);
         exp_we  = exp_en ? mq[0].dest_we : 1'b0;
         n_checks++;
         if (bus.alu_enable !== exp_en || bus.id_ready !== exp_rdy || bus.ex_dest_we !== exp_we) begin
            n_fail++; $display("FAIL rand_ctrl[%0d] got en=%b rdy=%b we=%b, want %b %b %b",
               c, bus.alu_enable, bus.id_ready, bus.ex_dest_we, exp_en, exp_rdy, exp_we);
         end
         if (exp_en) begin
            n_checks++;
            if (bus.ex_op !== mq[0].op || bus.ex_srcl !== mq[0].srcl ||
                bus.ex_srcr !== mq[0].srcr || bus.ex_dest !== mq[0].dest) begin
               n_fail++; $display("FAIL rand_data[%0d] got op=%h l=%h r=%h d=%h, want %h %h %h %h",
                  c, bus.ex_op, bus.ex_srcl, bus.ex_srcr, bus.ex_dest,
                  mq[0].op, mq[0].srcl, mq[0].srcr, mq[0].dest);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_back_pressure();
      test_back_to_back();
      test_forwarding();
      test_stall_refresh();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
